// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/flags and a one-cycle read latency.
// Flush clears pointers and count and overrides any same-cycle read or write.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count, w_cnt_nxt;
  logic              r_full, r_empty;
  logic [DATA_W-1:0] r_dout;
  logic              w_wr, w_rd;

  // Full/empty gate each side on its own, so a write to a full FIFO is
  // dropped even when a read is accepted in the same cycle.
  assign w_wr = wr_en && !r_full  && !flush;
  assign w_rd = rd_en && !r_empty && !flush;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_dout  <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) begin
        r_dout <= r_mem[r_rp];
        r_rp   <= r_rp + AW'(1);
      end
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;
  assign dout  = r_dout;
endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffering bridge between the UART ready/valid ports and a FIFO-style client:
// RX/TX FIFOs, TX drain FSM, RX overflow policy with drop counter, loopback.
module uart_fifo_bridge #(
  parameter int DATA_W          = 8,
  parameter int RX_DEPTH        = 32,
  parameter int TX_DEPTH        = 32,
  parameter int TX_AFULL        = 28,
  parameter int RX_DROP_ON_FULL = 0,
  parameter int DROP_W          = 16
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             uart_rx_data,
  input  logic                          uart_rx_valid,
  output logic                          uart_rx_ready,
  output logic [DATA_W-1:0]             uart_tx_data,
  output logic                          uart_tx_valid,
  input  logic                          uart_tx_ready,
  output logic [DATA_W-1:0]             rx_dout,
  input  logic                          rx_rd_en,
  output logic                          rx_empty,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
  input  logic [DATA_W-1:0]             tx_din,
  input  logic                          tx_wr_en,
  output logic                          tx_full,
  output logic                          tx_almost_full,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
  input  logic                          rx_flush,
  input  logic                          tx_flush,
  input  logic                          loopback,
  output logic [DROP_W-1:0]             drop_count
);
  localparam int TXC_W = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} tx_state_t;

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [DROP_W-1:0] r_drop;

  logic              w_rx_full, w_rx_ready, w_rx_wr;
  logic              w_tx_empty, w_tx_wr, w_tx_rd, w_drop;
  logic [DATA_W-1:0] w_tx_din, w_tx_dout;

  // In loopback the UART byte targets the TX FIFO, so TX fullness throttles it.
  assign w_rx_ready = loopback ? !tx_full
                    : ((RX_DROP_ON_FULL != 0) ? 1'b1 : !w_rx_full);
  assign w_rx_wr    = !loopback && uart_rx_valid && w_rx_ready;
  assign w_drop     = (RX_DROP_ON_FULL != 0) && !loopback && uart_rx_valid && w_rx_full;

  assign w_tx_wr    = loopback ? (uart_rx_valid && w_rx_ready) : tx_wr_en;
  assign w_tx_din   = loopback ? uart_rx_data : tx_din;

  // Drain reads are pulsed from IDLE, or back-to-back on a PRESENT handshake.
  assign w_tx_rd = !tx_flush && !w_tx_empty &&
                   ((r_state == S_IDLE) || (r_state == S_PRESENT && uart_tx_ready));

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .wr_en (w_rx_wr),
    .din   (uart_rx_data),
    .full  (w_rx_full),
    .rd_en (rx_rd_en),
    .dout  (rx_dout),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .wr_en (w_tx_wr),
    .din   (w_tx_din),
    .full  (tx_full),
    .rd_en (w_tx_rd),
    .dout  (w_tx_dout),
    .empty (w_tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (tx_flush) begin
      r_state    <= S_IDLE;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:    if (!w_tx_empty) r_state <= S_FETCH;
        S_FETCH: begin
          r_tx_data  <= w_tx_dout;
          r_tx_valid <= 1'b1;
          r_state    <= S_PRESENT;
        end
        S_PRESENT: if (uart_tx_ready) begin
          r_tx_valid <= 1'b0;
          r_state    <= w_tx_empty ? S_IDLE : S_FETCH;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_drop <= '0;
    else if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
  end

  assign uart_rx_ready  = w_rx_ready;
  assign uart_tx_valid  = r_tx_valid;
  assign uart_tx_data   = r_tx_data;
  assign tx_almost_full = (tx_count >= TXC_W'(TX_AFULL));
  assign drop_count     = r_drop;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized and directed bench for uart_fifo_bridge against a queue-based model;
// a second instance with drop-on-full policy covers overflow and saturation.
module tb_uart_fifo_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (backpressure policy)
  logic [7:0] in_rx_data, in_tx_din;
  logic       in_rx_valid, in_tx_ready, in_rd, in_tx_wr, in_rx_flush, in_tx_flush, in_loopback;
  logic       uart_rx_ready, uart_tx_valid, rx_empty, tx_full, tx_almost_full;
  logic [7:0] uart_tx_data, rx_dout;
  logic [5:0] rx_count, tx_count;
  logic [15:0] drop_count;

  uart_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .uart_rx_data(in_rx_data), .uart_rx_valid(in_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(in_tx_ready),
    .rx_dout(rx_dout), .rx_rd_en(in_rd), .rx_empty(rx_empty), .rx_count(rx_count),
    .tx_din(in_tx_din), .tx_wr_en(in_tx_wr), .tx_full(tx_full),
    .tx_almost_full(tx_almost_full), .tx_count(tx_count),
    .rx_flush(in_rx_flush), .tx_flush(in_tx_flush), .loopback(in_loopback),
    .drop_count(drop_count)
  );

  // drop-policy instance, narrow counter so saturation is reachable
  logic [7:0] d_rx_data, d_tx_din, d_uart_tx_data, d_rx_dout;
  logic       d_rx_valid, d_rd, d_rx_flush, d_zero;
  logic       d_uart_rx_ready, d_uart_tx_valid, d_rx_empty, d_tx_full, d_tx_afull;
  logic [5:0] d_rx_count, d_tx_count;
  logic [1:0] d_drop;

  uart_fifo_bridge #(.RX_DROP_ON_FULL(1), .DROP_W(2)) dut_d (
    .clk(clk), .rst(rst),
    .uart_rx_data(d_rx_data), .uart_rx_valid(d_rx_valid), .uart_rx_ready(d_uart_rx_ready),
    .uart_tx_data(d_uart_tx_data), .uart_tx_valid(d_uart_tx_valid), .uart_tx_ready(d_zero),
    .rx_dout(d_rx_dout), .rx_rd_en(d_rd), .rx_empty(d_rx_empty), .rx_count(d_rx_count),
    .tx_din(d_tx_din), .tx_wr_en(d_zero), .tx_full(d_tx_full),
    .tx_almost_full(d_tx_afull), .tx_count(d_tx_count),
    .rx_flush(d_rx_flush), .tx_flush(d_zero), .loopback(d_zero),
    .drop_count(d_drop)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: FIFO contents as queues, drain stage as a holding slot.
  logic [7:0] q_rx[$];
  logic [7:0] q_tx[$];
  logic [7:0] m_rx_dout, m_tx_data, m_fetch_data;
  bit         m_valid, m_fetch;

  function automatic bit m_ready();
    return in_loopback ? (q_tx.size() != 32) : (q_rx.size() != 32);
  endfunction

  task automatic model_reset();
    q_rx.delete(); q_tx.delete();
    m_rx_dout = 0; m_tx_data = 0; m_fetch_data = 0; m_valid = 0; m_fetch = 0;
  endtask

  task automatic model_step();
    int rxs = q_rx.size();
    int txs = q_tx.size();
    bit acc = in_rx_valid && m_ready();
    bit tx_w = in_loopback ? acc : in_tx_wr;
    logic [7:0] tx_d = in_loopback ? in_rx_data : in_tx_din;
    bit pop = 0;
    if (in_rx_flush) q_rx.delete();
    else begin
      if (in_rd && rxs > 0) m_rx_dout = q_rx.pop_front();
      if (!in_loopback && acc && rxs < 32) q_rx.push_back(in_rx_data);
    end
    if (in_tx_flush) begin
      q_tx.delete(); m_valid = 0; m_fetch = 0;
    end else begin
      if (m_fetch) begin
        m_tx_data = m_fetch_data; m_valid = 1; m_fetch = 0;
      end else if (m_valid) begin
        if (in_tx_ready) begin m_valid = 0; pop = (txs > 0); end
      end else pop = (txs > 0);
      if (pop) begin m_fetch_data = q_tx.pop_front(); m_fetch = 1; end
      if (tx_w && txs < 32) q_tx.push_back(tx_d);
    end
  endtask

  task automatic check_all();
    chk("rx_count", rx_count, q_rx.size());
    chk("rx_empty", rx_empty, q_rx.size() == 0);
    chk("rx_dout", rx_dout, m_rx_dout);
    chk("tx_count", tx_count, q_tx.size());
    chk("tx_full", tx_full, q_tx.size() == 32);
    chk("tx_afull", tx_almost_full, q_tx.size() >= 28);
    chk("tx_valid", uart_tx_valid, m_valid);
    chk("tx_data", uart_tx_data, m_tx_data);
    chk("drop_count", drop_count, 0);
  endtask

  task automatic check_reset();
    chk("rst_rx_count", rx_count, 0);   chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_empty", rx_empty, 1);   chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_afull", tx_almost_full, 0);
    chk("rst_tx_valid", uart_tx_valid, 0); chk("rst_tx_data", uart_tx_data, 0);
    chk("rst_rx_dout", rx_dout, 0);     chk("rst_drop", drop_count, 0);
    chk("rst_d_count", d_rx_count, 0);  chk("rst_d_drop", d_drop, 0);
  endtask

  task automatic set_idle();
    in_rx_data = 0; in_rx_valid = 0; in_tx_ready = 0; in_rd = 0; in_tx_din = 0;
    in_tx_wr = 0; in_rx_flush = 0; in_tx_flush = 0; in_loopback = 0;
    d_rx_data = 0; d_rx_valid = 0; d_rd = 0; d_rx_flush = 0; d_tx_din = 0; d_zero = 0;
  endtask

  // Inputs are set by the caller just after an edge; one clock is advanced.
  task automatic step();
    #1;
    chk("rx_ready", uart_rx_ready, m_ready());
    @(posedge clk); #1;
    model_step();
    check_all();
  endtask

  task automatic async_reset();
    set_idle();
    #3 rst = 1'b1;
    #1 check_reset();
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] got[$];
  task automatic collect(input int n);
    got.delete();
    for (int k = 0; k < n; k++) begin
      if (uart_tx_valid && in_tx_ready) got.push_back(uart_tx_data);
      step();
    end
  endtask

  int lat;
  int p_val[6] = '{70, 90, 60, 85, 60, 40};
  int p_rd [6] = '{50,  5, 70, 30, 20, 60};
  int p_wr [6] = '{50, 20, 40, 90, 60, 40};
  int p_rdy[6] = '{60, 30, 90,  5, 70, 50};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // drop-on-full instance: 34 pushes into 32 entries, then saturation
    for (int i = 0; i < 34; i++) begin
      d_rx_valid = 1; d_rx_data = 8'(i);
      step();
      chk("d_ready", d_uart_rx_ready, 1);
    end
    d_rx_valid = 0;
    chk("d_count_full", d_rx_count, 32);
    chk("d_drop_2", d_drop, 2);
    d_rx_valid = 1; d_rx_data = 8'hEE;
    step(); step();
    d_rx_valid = 0;
    chk("d_drop_sat", d_drop, 3);
    for (int i = 0; i < 32; i++) begin
      d_rd = 1; step();
      chk("d_order", d_rx_dout, 8'(i));
    end
    d_rd = 0;
    chk("d_empty", d_rx_empty, 1);
    d_rx_valid = 1; d_rx_data = 8'h77; d_rx_flush = 1; step();
    d_rx_valid = 0; d_rx_flush = 0;
    chk("d_flush_count", d_rx_count, 0);
    chk("d_flush_drop", d_drop, 3);

    // single byte, latency to uart_tx_valid
    in_tx_ready = 1; in_tx_wr = 1; in_tx_din = 8'hA5;
    step();
    in_tx_wr = 0; lat = 1;
    while (!uart_tx_valid && lat < 10) begin step(); lat++; end
    chk("tx_latency", lat, 3);
    chk("tx_a5", uart_tx_data, 8'hA5);
    step();
    chk("tx_count_0", tx_count, 0);

    // stalled transmitter holds the first byte, then drains in order
    in_tx_ready = 0;
    for (int i = 1; i <= 3; i++) begin in_tx_wr = 1; in_tx_din = 8'(i); step(); end
    in_tx_wr = 0;
    repeat (6) step();
    chk("hold_valid", uart_tx_valid, 1);
    chk("hold_data", uart_tx_data, 1);
    in_tx_ready = 1;
    collect(12);
    chk("drain_n", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], 8'(i + 1));

    // loopback: RX bytes echo out, client writes ignored
    in_loopback = 1;
    in_rx_valid = 1; in_rx_data = 8'h31; in_tx_wr = 1; in_tx_din = 8'hFF; step();
    in_rx_data = 8'h32; step();
    in_rx_valid = 0; in_tx_wr = 0;
    collect(12);
    chk("lb_n", got.size(), 2);
    if (got.size() == 2) begin chk("lb_0", got[0], 8'h31); chk("lb_1", got[1], 8'h32); end
    chk("lb_rx_empty", rx_empty, 1);
    in_loopback = 0;

    // RX backpressure at full
    for (int i = 0; i < 32; i++) begin in_rx_valid = 1; in_rx_data = 8'(8'h40 + i); step(); end
    #1 chk("bp_ready_0", uart_rx_ready, 0);
    in_rx_valid = 0; in_rd = 1; step();
    in_rd = 0;
    #1 chk("bp_ready_1", uart_rx_ready, 1);
    chk("bp_dout", rx_dout, 8'h40);
    in_rx_flush = 1; step();
    in_rx_flush = 0;
    chk("rx_flushed", rx_count, 0);

    // tx_flush while presenting with 4 queued
    in_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin in_tx_wr = 1; in_tx_din = 8'(8'h10 + i); step(); end
    in_tx_wr = 0; step();
    chk("pf_valid", uart_tx_valid, 1);
    chk("pf_count", tx_count, 4);
    in_tx_flush = 1; step();
    in_tx_flush = 0;
    chk("flush_valid", uart_tx_valid, 0);
    chk("flush_count", tx_count, 0);

    // reset mid-transfer
    for (int i = 0; i < 4; i++) begin in_tx_wr = 1; in_tx_din = 8'(8'h60 + i);
      in_rx_valid = 1; in_rx_data = 8'(i); step(); end
    in_tx_wr = 0; in_rx_valid = 0; step();
    async_reset();

    // randomized phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 300; c++) begin
        in_rx_valid = ($urandom_range(99) < p_val[ph]);
        in_rx_data  = 8'($urandom);
        in_rd       = ($urandom_range(99) < p_rd[ph]);
        in_tx_wr    = ($urandom_range(99) < p_wr[ph]);
        in_tx_din   = 8'($urandom);
        in_tx_ready = ($urandom_range(99) < p_rdy[ph]);
        in_rx_flush = ($urandom_range(99) == 0);
        in_tx_flush = ($urandom_range(99) == 0);
        if (c % 50 == 0) in_loopback = (ph == 2 || ph == 3) ? ($urandom_range(3) != 0) : 1'b0;
        step();
      end
      if (ph == 4) async_reset();
    end

    set_idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Parametrised buffering bridge between the on-chip UART ready/valid interface and a FIFO-style client such as the piano or a future command parser. It holds an RX FIFO and a TX FIFO, each with configurable width and depth. A TX drain FSM presents bytes to the UART with a proper valid-hold handshake. Added features: occupancy counts, almost-full flag, selectable RX overflow policy with a drop counter, per-FIFO flush, and a runtime loopback (echo) mode.

Parameters:
DATA_W, 8, byte width on both sides
RX_DEPTH, 32, RX FIFO entries; power of two, at least 2
TX_DEPTH, 32, TX FIFO entries; power of two, at least 2
TX_AFULL, 28, tx_almost_full asserted when tx_count >= TX_AFULL
RX_DROP_ON_FULL, 0, 0 = backpressure the UART when RX is full; 1 = always accept and drop when full
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
uart_rx_data  in  DATA_W  byte from UART receiver
uart_rx_valid  in  1  receiver byte valid
uart_rx_ready  out  1  bridge can accept a received byte
uart_tx_data  out  DATA_W  byte to UART transmitter
uart_tx_valid  out  1  byte presented to transmitter
uart_tx_ready  in  1  transmitter accepts byte
rx_dout  out  DATA_W  RX FIFO read data, valid the cycle after an accepted rx_rd_en
rx_rd_en  in  1  client read request
rx_empty  out  1  RX FIFO empty
rx_count  out  $clog2(RX_DEPTH+1)  RX occupancy
tx_din  in  DATA_W  client write data
tx_wr_en  in  1  client write request
tx_full  out  1  TX FIFO full
tx_almost_full  out  1  tx_count >= TX_AFULL
tx_count  out  $clog2(TX_DEPTH+1)  TX occupancy
rx_flush  in  1  synchronous clear of the RX FIFO
tx_flush  in  1  synchronous clear of the TX FIFO and the drain FSM
loopback  in  1  1 = route UART RX bytes into the TX FIFO
drop_count  out  DROP_W  bytes dropped on RX overflow; saturates

Behaviour:
- Reset values: all counts 0; rx_empty=1; tx_full=0; tx_almost_full=0; uart_tx_valid=0; uart_tx_data=0; rx_dout=0; drop_count=0; FSM=IDLE. Pointers are cleared.
- FIFO rules:
  - A write when full is ignored and a read when empty is ignored, even if the other operation happens in the same cycle.
  - A simultaneous read and write in any other state keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
  - rx_dout holds its last value when no read is accepted.
- RX path, loopback=0:
  - A write occurs when uart_rx_valid && uart_rx_ready.
  - uart_rx_ready = !rx_full when RX_DROP_ON_FULL=0, and 1 otherwise.
  - With RX_DROP_ON_FULL=1, a valid byte arriving while full is discarded and drop_count increments, saturating at all-ones.
- Loopback, loopback=1:
  - UART RX bytes are written into the TX FIFO, and uart_rx_ready = !tx_full.
  - The client tx_wr_en is ignored, and the RX FIFO receives no writes.
  - A change of loopback takes effect on the next cycle; bytes already buffered remain.
- TX drain FSM:
  - IDLE: if the TX FIFO is non-empty, pulse the internal read and go to FETCH.
  - FETCH: capture the FIFO dout into uart_tx_data, assert uart_tx_valid, and go to PRESENT.
  - PRESENT: hold data and valid until uart_tx_valid && uart_tx_ready. On that handshake, if the FIFO is non-empty, pulse the read and go to FETCH (valid drops for one cycle); otherwise deassert valid and go to IDLE.
  - Latency from the first write into an empty TX FIFO to uart_tx_valid is 3 cycles.
- Flush:
  - rx_flush zeroes the RX pointers and count; it has priority over a same-cycle write or read.
  - tx_flush zeroes the TX pointers and count, and forces the FSM to IDLE with uart_tx_valid=0 on the next edge. This abandons any presented byte.
  - drop_count is cleared only by rst.
- Reset asserted mid-operation immediately clears all state, asynchronously.
- tx_almost_full and the counts are registered, coherent with the FIFO state in the same cycle.

Decomposition:
- No shared package is required.
- A localparam for the FSM state encoding (IDLE, FETCH, PRESENT) is local to the module.
- One sub-module, sync_fifo, is parametrised by data_width and depth. It provides wr_en, din, full, rd_en, dout, empty, count and flush, with 1-cycle read latency. It is instantiated twice.

Test Plan:
- Write 0xA5 via tx_wr_en with uart_tx_ready=1 -> uart_tx_valid high 3 cycles later with data 0xA5; tx_count returns to 0.
- Hold uart_tx_ready=0 with 3 bytes queued -> uart_tx_valid and data stable; release ready -> bytes emitted in order 1,2,3.
- RX_DROP_ON_FULL=1, push 34 bytes with no reads -> rx_count=32, drop_count=2, first 32 bytes read back in order.
- RX_DROP_ON_FULL=0, RX full -> uart_rx_ready=0; one rx_rd_en -> uart_rx_ready=1 next cycle; rx_dout shows byte 0.
- loopback=1, UART RX sends 0x31 0x32 -> both appear on uart_tx_data in order; rx_empty stays 1; a client tx_wr_en of 0xFF is ignored.
- tx_flush while PRESENT with 4 queued -> uart_tx_valid=0 and tx_count=0 next cycle; rst mid-transfer -> all outputs at their reset values.
